mii_frame_transmitter: RTL and testbench
========================================

Name: mii_frame_transmitter

Overview:
Transmit-side counterpart of the MII receive path that writes received bytes into a frame RAM. On a start request it reads a stored frame from a dual-port RAM read port, one byte per two cycles. It emits the frame as MII nibbles in this order: preamble, SFD, payload, zero pad, IEEE 802.3 FCS, then enforces the inter-frame gap. It runs in the MII transmit clock domain and produces one nibble per clk cycle.

Parameters:
ADDR_W, 11, frame RAM address width; addresses wrap modulo 2^ADDR_W
LEN_W, 11, width of the frame length input, in bytes
MIN_FRAME, 60, minimum payload+header bytes before FCS; shorter frames are zero-padded; 0 disables padding
MAX_FRAME, 1514, largest accepted length
IFG_NIBBLES, 24, idle nibbles after the FCS (12 byte times)

Ports:
clk  in  1  MII transmit clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request; accepted only when busy=0
frame_base  in  ADDR_W  RAM address of the first frame byte; latched on accept
frame_len  in  LEN_W  payload byte count; latched on accept
abort  in  1  terminate the frame in progress
rd_addr  out  ADDR_W  RAM read address
rd_data  in  8  RAM read data; valid exactly 1 cycle after rd_addr
Tx_EN  out  1  MII transmit enable
Tx_ER  out  1  MII transmit error
Tx_data  out  4  MII nibble
busy  out  1  high from accept until the end of the IFG
done  out  1  one-cycle pulse when the frame completes normally
len_err  out  1  one-cycle pulse when start is rejected for length

Behaviour:
- Reset values: Tx_EN=0, Tx_ER=0, Tx_data=0, busy=0, done=0, len_err=0, rd_addr=0, state=IDLE. Reset mid-frame drops Tx_EN on the next edge with no IFG.
- All MII outputs are registered.
- Let cycle 0 be the cycle in which start is accepted. Tx_EN rises in cycle 1.
- States: IDLE -> PREAMBLE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
  - DATA is skipped when frame_len=0.
  - PAD is skipped when frame_len >= MIN_FRAME.
- PREAMBLE: 15 nibbles of 0x5 (cycles 1-15). SFD: 0xD in cycle 16.
- DATA: for each byte, the low nibble is sent first, then the high nibble.
  - The address is frame_base+i, truncated to ADDR_W bits.
  - Byte i is requested two cycles before its low nibble is sent. The first read is issued in cycle 15.
  - rd_data is captured into a holding register. The RAM is never read outside DATA.
- PAD: zero bytes until the total byte count is max(frame_len, MIN_FRAME).
- FCS: CRC-32 over the DATA and PAD bytes.
  - Polynomial 0x04C11DB7, reflected form 0xEDB88320, init 0xFFFFFFFF, updated nibble-wise LSB-first.
  - The result is complemented and sent as 8 nibbles, least significant nibble first.
- Frame length on the wire: 16 + 2*max(frame_len, MIN_FRAME) + 8 nibbles of Tx_EN=1.
- done pulses in the first IFG cycle. IFG holds Tx_EN=0 for IFG_NIBBLES cycles. busy falls in the cycle after the last IFG cycle.
- start handling:
  - start while busy is ignored, with no queueing.
  - start with frame_len > MAX_FRAME: no accept, busy stays 0, len_err pulses one cycle later.
- abort:
  - Sampled in PREAMBLE through FCS.
  - On the next cycle the block drives Tx_EN=1 and Tx_ER=1 (Tx_data=0) for one nibble, then enters IFG.
  - No done pulse. abort in IDLE or IFG has no effect.
- Tx_ER is 0 at all other times.

Decomposition:
- Package eth_tx_pkg holds:
  - state enum
  - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD
  - CRC_POLY_REFL=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3
- Sub-module crc32_nibble: combinational next-CRC from the current CRC and a 4-bit nibble. It is reusable by the receive-side checker.
- The top module holds the FSM, byte and nibble counters, read pipeline and output registers.

Test Plan:
- MIN_FRAME=0, RAM holds ASCII "123456789" at base 0x10, frame_len=9 -> 15x5, D, 1,3,2,3,…,9,3, then FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926). Tx_EN high for 42 cycles, done in the next cycle, busy low 24 cycles later.
- Default params, frame_len=20 -> 40 payload nibbles of RAM data, then 80 zero nibbles of pad. A bench CRC over the 60 bytes plus FCS yields residue 0xDEBB20E3; rd_addr takes only base..base+19.
- frame_base=0x7FE, frame_len=64 -> rd_addr sequence 0x7FE, 0x7FF, 0x000, … with no pad.
- start with frame_len=1515 -> len_err pulse, busy=0, Tx_EN never rises. A second start while busy -> ignored, and the first frame is unchanged.
- abort asserted in DATA cycle 30 -> cycle 31 has Tx_EN=1, Tx_ER=1; cycle 32 has Tx_EN=0; no done pulse; busy low after 24 IFG cycles.
- reset asserted mid-FCS -> next edge gives all outputs at reset values; a new start is accepted in the following cycle.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet MII transmit path.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, IFG
  } tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_nibble.sv
// Combinational CRC-32 step over one nibble, LSB first, reflected polynomial.
module crc32_nibble
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nibble[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                  c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/mii_frame_transmitter.sv
// Streams a stored frame from RAM onto MII as preamble, SFD, payload, pad and FCS,
// then holds the inter-frame gap. 'state' always names what is on the wire this cycle.
module mii_frame_transmitter
  import eth_tx_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int LEN_W       = 11,
  parameter int MIN_FRAME   = 60,
  parameter int MAX_FRAME   = 1514,
  parameter int IFG_NIBBLES = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              Tx_EN,
  output logic              Tx_ER,
  output logic [3:0]        Tx_data,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_NIBBLES - 1);

  tx_state_t         state;
  logic [7:0]        cnt;
  logic              half;
  logic [LEN_W-1:0]  byte_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  total_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        hold_hi;
  logic [31:0]       crc;
  logic [31:0]       crc_upd;
  logic [3:0]        data_nib;
  logic              last_data;
  logic              last_pad;

  assign last_data = (byte_cnt == len_q - LEN_W'(1));
  assign last_pad  = (byte_cnt == total_q - LEN_W'(1));

  // Nibble about to be loaded onto the wire in DATA/PAD; zero whenever padding.
  always_comb begin
    data_nib = 4'h0;
    if (state == SFD && len_q != '0)      data_nib = rd_data[3:0];
    else if (state == DATA && !half)      data_nib = hold_hi;
    else if (state == DATA && !last_data) data_nib = rd_data[3:0];
  end

  crc32_nibble u_crc (
    .crc      (crc),
    .nibble   (data_nib),
    .crc_next (crc_upd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= 1'b0;
      byte_cnt <= '0;
      len_q    <= '0;
      total_q  <= '0;
      base_q   <= '0;
      hold_hi  <= '0;
      crc      <= CRC_INIT;
      rd_addr  <= '0;
      Tx_EN    <= 1'b0;
      Tx_ER    <= 1'b0;
      Tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      if (abort && (state inside {PREAMBLE, SFD, DATA, PAD, FCS})) begin
        state   <= ABORT;
        Tx_EN   <= 1'b1;
        Tx_ER   <= 1'b1;
        Tx_data <= 4'h0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (frame_len > MAX_LEN) begin
                len_err <= 1'b1;
              end else begin
                state   <= PREAMBLE;
                busy    <= 1'b1;
                Tx_EN   <= 1'b1;
                Tx_data <= PREAMBLE_NIB;
                cnt     <= '0;
                len_q   <= frame_len;
                total_q <= (frame_len < MIN_LEN) ? MIN_LEN : frame_len;
                base_q  <= frame_base;
                crc     <= CRC_INIT;
              end
            end
          end
          PREAMBLE: begin
            // First read goes out one cycle before SFD so byte 0 lands right after it.
            if (cnt == 8'd13 && len_q != '0) rd_addr <= base_q;
            if (cnt == 8'd14) begin
              state   <= SFD;
              Tx_data <= SFD_NIB;
            end else begin
              cnt     <= cnt + 8'd1;
              Tx_data <= PREAMBLE_NIB;
            end
          end
          SFD: begin
            byte_cnt <= '0;
            half     <= 1'b0;
            if (len_q != '0) begin
              state   <= DATA;
              Tx_data <= data_nib;
              hold_hi <= rd_data[7:4];
              crc     <= crc_upd;
              if (len_q > LEN_W'(1)) rd_addr <= rd_addr + ADDR_W'(1);
            end else if (total_q != '0) begin
              state   <= PAD;
              Tx_data <= data_nib;
              crc     <= crc_upd;
            end else begin
              state   <= FCS;
              cnt     <= '0;
              Tx_data <= ~crc[3:0];
              crc     <= ~crc >> 4;
            end
          end
          DATA: begin
            if (!half) begin
              half    <= 1'b1;
              Tx_data <= data_nib;
              crc     <= crc_upd;
            end else if (!last_data) begin
              half     <= 1'b0;
              byte_cnt <= byte_cnt + LEN_W'(1);
              Tx_data  <= data_nib;
              hold_hi  <= rd_data[7:4];
              crc      <= crc_upd;
              if (byte_cnt + LEN_W'(2) < len_q) rd_addr <= rd_addr + ADDR_W'(1);
            end else if (len_q < total_q) begin
              state    <= PAD;
              half     <= 1'b0;
              byte_cnt <= byte_cnt + LEN_W'(1);
              Tx_data  <= data_nib;
              crc      <= crc_upd;
            end else begin
              state   <= FCS;
              cnt     <= '0;
              Tx_data <= ~crc[3:0];
              crc     <= ~crc >> 4;
            end
          end
          PAD: begin
            if (!half) begin
              half    <= 1'b1;
              Tx_data <= data_nib;
              crc     <= crc_upd;
            end else if (!last_pad) begin
              half     <= 1'b0;
              byte_cnt <= byte_cnt + LEN_W'(1);
              Tx_data  <= data_nib;
              crc      <= crc_upd;
            end else begin
              state   <= FCS;
              cnt     <= '0;
              Tx_data <= ~crc[3:0];
              crc     <= ~crc >> 4;
            end
          end
          FCS: begin
            // crc already holds the complemented remainder, shifted one nibble per cycle.
            if (cnt == 8'd7) begin
              state   <= IFG;
              cnt     <= '0;
              Tx_EN   <= 1'b0;
              Tx_data <= 4'h0;
              done    <= 1'b1;
            end else begin
              cnt     <= cnt + 8'd1;
              Tx_data <= crc[3:0];
              crc     <= crc >> 4;
            end
          end
          ABORT: begin
            state   <= IFG;
            cnt     <= '0;
            Tx_EN   <= 1'b0;
            Tx_ER   <= 1'b0;
            Tx_data <= 4'h0;
          end
          IFG: begin
            if (cnt == IFG_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_transmitter.sv
// Scoreboard bench: expected wire nibbles are queued at start and popped as Tx_EN nibbles appear.
module tb_mii_frame_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start0, abort, abort0;
  logic [10:0] frame_base, frame_len;
  logic [10:0] rd_addr, rd_addr0;
  logic [7:0]  rd_data, rd_data0;
  logic        Tx_EN, Tx_ER, busy, done, len_err;
  logic        Tx_EN0, Tx_ER0, busy0, done0, len_err0;
  logic [3:0]  Tx_data, Tx_data0;

  logic [7:0]  mem [2048];
  logic [3:0]  exp_q[$];
  logic [3:0]  exp0_q[$];
  logic [3:0]  rx_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  mii_frame_transmitter dut (
    .clk(clk), .reset(reset), .start(start), .frame_base(frame_base),
    .frame_len(frame_len), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .Tx_EN(Tx_EN), .Tx_ER(Tx_ER), .Tx_data(Tx_data), .busy(busy), .done(done),
    .len_err(len_err)
  );

  mii_frame_transmitter #(.MIN_FRAME(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .frame_base(frame_base),
    .frame_len(frame_len), .abort(abort0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .Tx_EN(Tx_EN0), .Tx_ER(Tx_ER0), .Tx_data(Tx_data0), .busy(busy0), .done(done0),
    .len_err(len_err0)
  );

  // Frame RAM read ports with one cycle of latency.
  always @(posedge clk) begin
    rd_data  <= mem[rd_addr];
    rd_data0 <= mem[rd_addr0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, expv);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic pushNib(input bit sel, input logic [3:0] n);
    if (sel) exp0_q.push_back(n);
    else     exp_q.push_back(n);
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic applyStimulus(input bit sel, input logic [10:0] base, input logic [10:0] len);
    int          minf, total;
    logic [31:0] c;
    logic [7:0]  b;
    logic [10:0] a;
    frame_base = base;
    frame_len  = len;
    if (sel) start0 = 1'b1;
    else     start  = 1'b1;
    if (len <= 11'd1514) begin
      minf  = sel ? 0 : 60;
      total = (int'(len) < minf) ? minf : int'(len);
      for (int i = 0; i < 15; i++) pushNib(sel, 4'h5);
      pushNib(sel, 4'hD);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < total; i++) begin
        a = base + 11'(i);
        b = (i < int'(len)) ? mem[a] : 8'h00;
        c = crcByte(c, b);
        pushNib(sel, b[3:0]);
        pushNib(sel, b[7:4]);
      end
      c = ~c;
      for (int k = 0; k < 8; k++) pushNib(sel, c[4*k +: 4]);
    end
    @(negedge clk);
    start  = 1'b0;
    start0 = 1'b0;
    cyc    = 1;
  endtask

  task automatic advanceTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (Tx_EN === 1'b1 && Tx_ER === 1'b0) begin
      if (exp_q.size() == 0) checkOutput("dut_extra_nibble", 32'd1, 32'd0);
      else checkOutput("dut_nibble", 32'(Tx_data), 32'(exp_q.pop_front()));
    end
    if (Tx_EN0 === 1'b1 && Tx_ER0 === 1'b0) begin
      if (exp0_q.size() == 0) checkOutput("dut0_extra_nibble", 32'd1, 32'd0);
      else checkOutput("dut0_nibble", 32'(Tx_data0), 32'(exp0_q.pop_front()));
    end
  end

  initial begin
    int          bad, cnt_en, cnt_done;
    logic [31:0] res;
    logic [7:0]  str [9];
    reset = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0; abort0 = 1'b0;
    frame_base = '0; frame_len = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) mem[16 + i] = str[i];

    repeat (3) @(negedge clk);
    checkOutput("reset_tx_en", 32'(Tx_EN), 32'd0);
    checkOutput("reset_tx_er", 32'(Tx_ER), 32'd0);
    checkOutput("reset_tx_data", 32'(Tx_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_len_err", 32'(len_err), 32'd0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;

    // "123456789" with padding disabled: known CRC 0xCBF43926.
    applyStimulus(1'b1, 11'h010, 11'd9);
    checkOutput("t1_busy_rise", 32'(busy0), 32'd1);
    checkOutput("t1_en_rise", 32'(Tx_EN0), 32'd1);
    advanceTo(42);
    checkOutput("t1_en_last", 32'(Tx_EN0), 32'd1);
    checkOutput("t1_no_early_done", 32'(done0), 32'd0);
    advanceTo(43);
    checkOutput("t1_en_fall", 32'(Tx_EN0), 32'd0);
    checkOutput("t1_done", 32'(done0), 32'd1);
    advanceTo(44);
    checkOutput("t1_done_pulse", 32'(done0), 32'd0);
    advanceTo(66);
    checkOutput("t1_busy_ifg", 32'(busy0), 32'd1);
    advanceTo(67);
    checkOutput("t1_busy_fall", 32'(busy0), 32'd0);
    checkOutput("t1_queue_empty", 32'(exp0_q.size()), 32'd0);

    // 20-byte frame padded to 60: address range and residue over the wire bytes.
    applyStimulus(1'b0, 11'h100, 11'd20);
    bad = 0;
    rx_q.delete();
    for (int c = 1; c <= 144; c++) begin
      advanceTo(c);
      if (c >= 15 && (rd_addr < 11'h100 || rd_addr > 11'h113)) bad++;
      if (c >= 17) rx_q.push_back(Tx_data);
      if (c == 15) checkOutput("t2_rd_first", 32'(rd_addr), 32'h100);
      if (c == 17) checkOutput("t2_rd_second", 32'(rd_addr), 32'h101);
      if (c == 53) checkOutput("t2_rd_last", 32'(rd_addr), 32'h113);
    end
    checkOutput("t2_rd_range", 32'(bad), 32'd0);
    checkOutput("t2_rx_count", 32'(rx_q.size()), 32'd128);
    res = 32'hFFFFFFFF;
    for (int k = 0; k + 1 < rx_q.size(); k += 2) res = crcByte(res, {rx_q[k+1], rx_q[k]});
    checkOutput("t2_residue", res, 32'hDEBB20E3);
    advanceTo(145);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_en_fall", 32'(Tx_EN), 32'd0);
    advanceTo(169);
    checkOutput("t2_busy_fall", 32'(busy), 32'd0);
    checkOutput("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap, no pad, and a second start while busy that must be ignored.
    applyStimulus(1'b0, 11'h7FE, 11'd64);
    advanceTo(15);  checkOutput("t3_rd_7fe", 32'(rd_addr), 32'h7FE);
    advanceTo(17);  checkOutput("t3_rd_7ff", 32'(rd_addr), 32'h7FF);
    advanceTo(19);  checkOutput("t3_rd_000", 32'(rd_addr), 32'h000);
    advanceTo(21);  checkOutput("t3_rd_001", 32'(rd_addr), 32'h001);
    advanceTo(50);
    start = 1'b1; frame_len = 11'd5; frame_base = 11'h000;
    advanceTo(51);
    start = 1'b0;
    checkOutput("t3_busy_hold", 32'(busy), 32'd1);
    advanceTo(141); checkOutput("t3_rd_03d", 32'(rd_addr), 32'h03D);
    advanceTo(152); checkOutput("t3_en_last", 32'(Tx_EN), 32'd1);
    advanceTo(153); checkOutput("t3_done", 32'(done), 32'd1);
    advanceTo(177); checkOutput("t3_busy_fall", 32'(busy), 32'd0);
    cnt_en = 0;
    for (int c = 178; c <= 190; c++) begin
      advanceTo(c);
      if (Tx_EN !== 1'b0 || busy !== 1'b0) cnt_en++;
    end
    checkOutput("t3_no_queued_start", 32'(cnt_en), 32'd0);
    checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Over-length request is rejected.
    applyStimulus(1'b0, 11'h000, 11'd1515);
    checkOutput("t4_len_err", 32'(len_err), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    cnt_en = 0;
    for (int c = 2; c <= 21; c++) begin
      advanceTo(c);
      if (c == 2) checkOutput("t4_len_err_pulse", 32'(len_err), 32'd0);
      if (Tx_EN !== 1'b0 || busy !== 1'b0) cnt_en++;
    end
    checkOutput("t4_no_tx", 32'(cnt_en), 32'd0);

    // Abort in the middle of DATA.
    applyStimulus(1'b0, 11'h100, 11'd20);
    advanceTo(30);
    abort = 1'b1;
    cnt_done = 0;
    advanceTo(31);
    abort = 1'b0;
    checkOutput("t5_err_en", 32'(Tx_EN), 32'd1);
    checkOutput("t5_err_er", 32'(Tx_ER), 32'd1);
    checkOutput("t5_err_data", 32'(Tx_data), 32'd0);
    for (int c = 31; c <= 56; c++) begin
      advanceTo(c);
      if (done !== 1'b0) cnt_done++;
      if (c == 32) begin
        checkOutput("t5_en_fall", 32'(Tx_EN), 32'd0);
        checkOutput("t5_er_fall", 32'(Tx_ER), 32'd0);
        exp_q.delete();
      end
      if (c == 55) checkOutput("t5_busy_ifg", 32'(busy), 32'd1);
    end
    checkOutput("t5_busy_fall", 32'(busy), 32'd0);
    checkOutput("t5_no_done", 32'(cnt_done), 32'd0);

    // Reset during FCS, then an immediate zero-length (all pad) frame.
    applyStimulus(1'b0, 11'h100, 11'd20);
    advanceTo(140);
    reset = 1'b1;
    advanceTo(141);
    reset = 1'b0;
    checkOutput("t6_rst_en", 32'(Tx_EN), 32'd0);
    checkOutput("t6_rst_er", 32'(Tx_ER), 32'd0);
    checkOutput("t6_rst_data", 32'(Tx_data), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_rd_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    applyStimulus(1'b0, 11'h200, 11'd0);
    checkOutput("t6_restart_en", 32'(Tx_EN), 32'd1);
    checkOutput("t6_restart_busy", 32'(busy), 32'd1);
    advanceTo(145); checkOutput("t6_done", 32'(done), 32'd1);
    advanceTo(169); checkOutput("t6_busy_fall", 32'(busy), 32'd0);
    checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
